// File: rtl/cpu_mtimer_pkg.sv
// Shared definitions for the machine timer: register offsets, register select and byte-lane merge.
package cpu_mtimer_pkg;

  localparam logic [4:0] MTIMER_MTIME_LO    = 5'h00;
  localparam logic [4:0] MTIMER_MTIME_HI    = 5'h04;
  localparam logic [4:0] MTIMER_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] MTIMER_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] MTIMER_MSIP        = 5'h10;

  typedef enum logic [2:0] {
    SEL_MTIME_LO    = 3'd0,
    SEL_MTIME_HI    = 3'd1,
    SEL_MTIMECMP_LO = 3'd2,
    SEL_MTIMECMP_HI = 3'd3,
    SEL_MSIP        = 3'd4,
    SEL_NONE        = 3'd7
  } reg_sel_e;

  // Byte offset bits [1:0] do not take part in the decode.
  function automatic reg_sel_e decode_addr(input logic [4:0] addr);
    case (addr & 5'h1C)
      MTIMER_MTIME_LO:    return SEL_MTIME_LO;
      MTIMER_MTIME_HI:    return SEL_MTIME_HI;
      MTIMER_MTIMECMP_LO: return SEL_MTIMECMP_LO;
      MTIMER_MTIMECMP_HI: return SEL_MTIMECMP_HI;
      MTIMER_MSIP:        return SEL_MSIP;
      default:            return SEL_NONE;
    endcase
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] r;
    r = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (wstrb[i]) r[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/cpu_mtimer_if.sv
// Peripheral bus request/response bundle for the machine timer.
interface cpu_mtimer_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_write;
  logic [4:0]      req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [3:0]      req_wstrb;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb,
    input  rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
    output rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/cpu_mtimer_prescaler.sv
// Free-running divider: tick is high for one cycle every PRESCALE clk cycles.
module cpu_mtimer_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/cpu_mtimer.sv
// Memory-mapped mtime/mtimecmp/msip block driving registered mti/msi pending lines.
// Optional build macro MTIMER_SNAPSHOT_EN: reading mtime lo latches mtime hi for a coherent 64-bit read.
module cpu_mtimer
  import cpu_mtimer_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned PRESCALE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  cpu_mtimer_if.slave  bus,
  output logic         mti_pending,
  output logic         msi_pending
);
  logic            tick;
  logic [63:0]     mtime, mtime_nxt;
  logic [63:0]     mtimecmp, mtimecmp_nxt;
  logic            msip, msip_nxt;
  logic            wr, rd;
  reg_sel_e        sel;
  logic [31:0]     hi_view;
  logic [XLEN-1:0] rd_value;

  cpu_mtimer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign sel = decode_addr(bus.req_addr);
  assign wr  = bus.req_valid & bus.req_write;
  assign rd  = bus.req_valid & ~bus.req_write;

`ifdef MTIMER_SNAPSHOT_EN
  logic [31:0] shadow_hi, shadow_nxt;

  always_comb begin
    shadow_nxt = shadow_hi;
    if (rd && sel == SEL_MTIME_LO) shadow_nxt = mtime[63:32];
    if (wr && sel == SEL_MTIME_HI) shadow_nxt = mtime_nxt[63:32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shadow_hi <= '0;
    else        shadow_hi <= shadow_nxt;
  end

  assign hi_view = shadow_hi;
`else
  assign hi_view = mtime[63:32];
`endif

  always_comb begin
    rd_value = '0;
    case (sel)
      SEL_MTIME_LO:    rd_value = mtime[31:0];
      SEL_MTIME_HI:    rd_value = hi_view;
      SEL_MTIMECMP_LO: rd_value = mtimecmp[31:0];
      SEL_MTIMECMP_HI: rd_value = mtimecmp[63:32];
      SEL_MSIP:        rd_value = {{(XLEN-1){1'b0}}, msip};
      default:         rd_value = '0;
    endcase
  end

  // A write to either mtime half replaces the increment for that cycle; the
  // unwritten half and bytes keep their pre-increment value.
  always_comb begin
    mtime_nxt    = tick ? mtime + 64'd1 : mtime;
    mtimecmp_nxt = mtimecmp;
    msip_nxt     = msip;
    if (wr) begin
      case (sel)
        SEL_MTIME_LO:
          mtime_nxt = {mtime[63:32], merge_bytes(mtime[31:0], bus.req_wdata, bus.req_wstrb)};
        SEL_MTIME_HI:
          mtime_nxt = {merge_bytes(mtime[63:32], bus.req_wdata, bus.req_wstrb), mtime[31:0]};
        SEL_MTIMECMP_LO:
          mtimecmp_nxt[31:0] = merge_bytes(mtimecmp[31:0], bus.req_wdata, bus.req_wstrb);
        SEL_MTIMECMP_HI:
          mtimecmp_nxt[63:32] = merge_bytes(mtimecmp[63:32], bus.req_wdata, bus.req_wstrb);
        SEL_MSIP:
          if (bus.req_wstrb[0]) msip_nxt = bus.req_wdata[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime         <= '0;
      mtimecmp      <= '1;
      msip          <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      mti_pending   <= 1'b0;
      msi_pending   <= 1'b0;
    end else begin
      mtime         <= mtime_nxt;
      mtimecmp      <= mtimecmp_nxt;
      msip          <= msip_nxt;
      bus.rsp_valid <= bus.req_valid;
      bus.rsp_rdata <= rd ? rd_value : '0;
      mti_pending   <= (mtime >= mtimecmp);
      msi_pending   <= msip;
    end
  end
endmodule

// File: tb/tb_cpu_mtimer.sv
// Bench for cpu_mtimer: two instances (PRESCALE 1 and 4) on shared stimulus, checked against a timing model.
module tb_cpu_mtimer;
  localparam int unsigned P0 = 1;
  localparam int unsigned P1 = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [4:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        mti0, msi0, mti1, msi1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_mtimer_if #(.XLEN(32)) bus0 ();
  cpu_mtimer_if #(.XLEN(32)) bus1 ();

  assign bus0.req_valid = req_valid;
  assign bus0.req_write = req_write;
  assign bus0.req_addr  = req_addr;
  assign bus0.req_wdata = req_wdata;
  assign bus0.req_wstrb = req_wstrb;
  assign bus1.req_valid = req_valid;
  assign bus1.req_write = req_write;
  assign bus1.req_addr  = req_addr;
  assign bus1.req_wdata = req_wdata;
  assign bus1.req_wstrb = req_wstrb;

  cpu_mtimer #(.XLEN(32), .PRESCALE(P0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .mti_pending(mti0), .msi_pending(msi0)
  );
  cpu_mtimer #(.XLEN(32), .PRESCALE(P1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .mti_pending(mti1), .msi_pending(msi1)
  );

  // Reference model: architectural state plus a count of cycles since reset.
  typedef struct {
    logic [63:0] mtime;
    logic [63:0] cmp;
    logic        msip;
    logic [31:0] shadow;
    int unsigned n;
    logic        e_rv;
    logic [31:0] e_rd;
    logic        e_mti;
    logic        e_msi;
  } mstate_t;

  mstate_t ms0, ms1;

  function automatic mstate_t model_reset();
    mstate_t r;
    r.mtime = 64'd0; r.cmp = {64{1'b1}}; r.msip = 1'b0; r.shadow = 32'd0; r.n = 0;
    r.e_rv = 1'b0; r.e_rd = 32'd0; r.e_mti = 1'b0; r.e_msi = 1'b0;
    return r;
  endfunction

  function automatic mstate_t model_step(input mstate_t s, input int unsigned p,
                                         input logic v, input logic w, input logic [4:0] a,
                                         input logic [31:0] d, input logic [3:0] st);
    mstate_t     r;
    logic [31:0] mask, rv;
    int unsigned idx;
    r    = s;
    mask = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
    idx  = int'(a) / 4;
    rv   = 32'd0;
    case (idx)
      0: rv = s.mtime[31:0];
`ifdef MTIMER_SNAPSHOT_EN
      1: rv = s.shadow;
`else
      1: rv = s.mtime[63:32];
`endif
      2: rv = s.cmp[31:0];
      3: rv = s.cmp[63:32];
      4: rv = {31'd0, s.msip};
      default: rv = 32'd0;
    endcase
    r.e_rv  = v;
    r.e_rd  = (v && !w) ? rv : 32'd0;
    r.e_mti = (s.mtime >= s.cmp);
    r.e_msi = s.msip;
    if (!(v && w && idx <= 1) && (s.n % p == p - 1)) r.mtime = s.mtime + 64'd1;
    r.n = s.n + 1;
    if (v && !w && idx == 0) r.shadow = s.mtime[63:32];
    if (v && w) begin
      case (idx)
        0: r.mtime[31:0]  = (s.mtime[31:0]  & ~mask) | (d & mask);
        1: begin
          r.mtime[63:32] = (s.mtime[63:32] & ~mask) | (d & mask);
          r.shadow       = r.mtime[63:32];
        end
        2: r.cmp[31:0]  = (s.cmp[31:0]  & ~mask) | (d & mask);
        3: r.cmp[63:32] = (s.cmp[63:32] & ~mask) | (d & mask);
        4: if (st[0]) r.msip = d[0];
        default: ;
      endcase
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms0 <= model_reset();
      ms1 <= model_reset();
    end else begin
      ms0 <= model_step(ms0, P0, req_valid, req_write, req_addr, req_wdata, req_wstrb);
      ms1 <= model_step(ms1, P1, req_valid, req_write, req_addr, req_wdata, req_wstrb);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_rsp_valid0", 32'(bus0.rsp_valid), 32'(ms0.e_rv));
      chk("m_mti0", 32'(mti0), 32'(ms0.e_mti));
      chk("m_msi0", 32'(msi0), 32'(ms0.e_msi));
      if (ms0.e_rv) chk("m_rsp_rdata0", bus0.rsp_rdata, ms0.e_rd);
      chk("m_rsp_valid1", 32'(bus1.rsp_valid), 32'(ms1.e_rv));
      chk("m_mti1", 32'(mti1), 32'(ms1.e_mti));
      chk("m_msi1", 32'(msi1), 32'(ms1.e_msi));
      if (ms1.e_rv) chk("m_rsp_rdata1", bus1.rsp_rdata, ms1.e_rd);
    end
  end

  task automatic op(input logic w, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_msi;
  } vec_t;

  initial begin
    vec_t        tbl[17];
    logic [31:0] samp[20];
    int          last, nchg;
    logic [31:0] v;
    logic [4:0]  a;
    int unsigned idx;

    tbl[0]  = '{1'b0, 5'h08, 32'h0,        4'h0, 32'hFFFFFFFF, 1'b0};
    tbl[1]  = '{1'b0, 5'h0C, 32'h0,        4'h0, 32'hFFFFFFFF, 1'b0};
    tbl[2]  = '{1'b0, 5'h10, 32'h0,        4'h0, 32'h00000000, 1'b0};
    tbl[3]  = '{1'b0, 5'h14, 32'h0,        4'h0, 32'h00000000, 1'b0};
    tbl[4]  = '{1'b0, 5'h1C, 32'h0,        4'h0, 32'h00000000, 1'b0};
    tbl[5]  = '{1'b1, 5'h14, 32'hDEADBEEF, 4'hF, 32'h00000000, 1'b0};
    tbl[6]  = '{1'b0, 5'h14, 32'h0,        4'h0, 32'h00000000, 1'b0};
    tbl[7]  = '{1'b1, 5'h10, 32'h1,        4'h2, 32'h00000000, 1'b0};
    tbl[8]  = '{1'b0, 5'h10, 32'h0,        4'h0, 32'h00000000, 1'b0};
    tbl[9]  = '{1'b1, 5'h10, 32'h1,        4'h1, 32'h00000000, 1'b0};
    tbl[10] = '{1'b0, 5'h10, 32'h0,        4'h0, 32'h00000001, 1'b1};
    tbl[11] = '{1'b1, 5'h08, 32'h12345678, 4'h5, 32'h00000000, 1'b1};
    tbl[12] = '{1'b0, 5'h0B, 32'h0,        4'h0, 32'hFF34FF78, 1'b1};
    tbl[13] = '{1'b1, 5'h10, 32'h0,        4'hF, 32'h00000000, 1'b1};
    tbl[14] = '{1'b0, 5'h10, 32'h0,        4'h0, 32'h00000000, 1'b0};
    tbl[15] = '{1'b1, 5'h08, 32'hFFFFFFFF, 4'hF, 32'h00000000, 1'b0};
    tbl[16] = '{1'b0, 5'h09, 32'h0,        4'h0, 32'hFFFFFFFF, 1'b0};

    do_reset();
    chk("reset_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    chk("reset_rsp_rdata", bus0.rsp_rdata, 32'd0);
    chk("reset_mti", 32'(mti0), 32'd0);
    chk("reset_msi", 32'(msi0), 32'd0);

    for (int i = 0; i < 17; i++) begin
      op(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb);
      chk("tbl_rsp_valid", 32'(bus0.rsp_valid), 32'd1);
      chk("tbl_rdata0", bus0.rsp_rdata, tbl[i].exp_rd);
      chk("tbl_rdata1", bus1.rsp_rdata, tbl[i].exp_rd);
      chk("tbl_msi0", 32'(msi0), 32'(tbl[i].exp_msi));
      chk("tbl_msi1", 32'(msi1), 32'(tbl[i].exp_msi));
    end
    idle(1);
    chk("idle_rsp_valid", 32'(bus0.rsp_valid), 32'd0);

    // PRESCALE=4 instance: rate and spacing of increments.
    do_reset();
    idle(40);
    op(1'b0, 5'h00, 32'h0, 4'h0);
    total++;
    if (bus1.rsp_rdata < 32'd9 || bus1.rsp_rdata > 32'd11) begin
      bad++;
      $display("FAIL p4_rate: got %0d expected 9..11", bus1.rsp_rdata);
    end
    for (int i = 0; i < 20; i++) begin
      op(1'b0, 5'h00, 32'h0, 4'h0);
      samp[i] = bus1.rsp_rdata;
    end
    last = -1;
    nchg = 0;
    for (int i = 1; i < 20; i++) begin
      if (samp[i] != samp[i-1]) begin
        nchg++;
        chk("p4_step", samp[i], samp[i-1] + 32'd1);
        if (last >= 0) chk("p4_spacing", 32'(i - last), 32'd4);
        last = i;
      end
    end
    total++;
    if (nchg < 4 || nchg > 5) begin
      bad++;
      $display("FAIL p4_changes: got %0d expected 4..5", nchg);
    end

    // 64-bit carry on the PRESCALE=1 instance.
    op(1'b1, 5'h04, 32'hFFFFFFFF, 4'hF);
    op(1'b1, 5'h00, 32'hFFFFFFFE, 4'hF);
    op(1'b0, 5'h00, 32'h0, 4'h0); chk("carry_lo_fe", bus0.rsp_rdata, 32'hFFFFFFFE);
    op(1'b0, 5'h00, 32'h0, 4'h0); chk("carry_lo_ff", bus0.rsp_rdata, 32'hFFFFFFFF);
    op(1'b0, 5'h00, 32'h0, 4'h0); chk("carry_lo_0",  bus0.rsp_rdata, 32'h00000000);
    op(1'b0, 5'h04, 32'h0, 4'h0); chk("carry_hi_0",  bus0.rsp_rdata, 32'h00000000);

    // mti_pending rise and fall timing.
    op(1'b1, 5'h0C, 32'hFFFFFFFF, 4'hF);
    op(1'b1, 5'h04, 32'h0, 4'hF);
    op(1'b1, 5'h00, 32'd100, 4'hF);
    op(1'b1, 5'h0C, 32'h0, 4'hF);
    op(1'b1, 5'h08, 32'd110, 4'hF);
    chk("mti_early", 32'(mti0), 32'd0);
    for (int j = 3; j <= 16; j++) begin
      idle(1);
      chk("mti_rise", 32'(mti0), (j >= 11) ? 32'd1 : 32'd0);
    end
    op(1'b1, 5'h0C, 32'hFFFFFFFF, 4'hF);
    chk("mti_hold", 32'(mti0), 32'd1);
    idle(1);
    chk("mti_fall", 32'(mti0), 32'd0);

    // msip byte-lane gating and one-cycle latency.
    op(1'b1, 5'h10, 32'h1, 4'h2); chk("msi_strb2_a", 32'(msi0), 32'd0);
    idle(1);                      chk("msi_strb2_b", 32'(msi0), 32'd0);
    op(1'b1, 5'h10, 32'h1, 4'h1); chk("msi_lat", 32'(msi0), 32'd0);
    idle(1);                      chk("msi_set", 32'(msi0), 32'd1);
    op(1'b1, 5'h10, 32'h0, 4'h1);
    idle(1);                      chk("msi_clr", 32'(msi0), 32'd0);

    // Partial write to mtime lo in a tick cycle suppresses the increment.
    op(1'b1, 5'h00, 32'h12340000, 4'hF);
    op(1'b1, 5'h00, 32'hAAAA5555, 4'h3);
    op(1'b0, 5'h00, 32'h0, 4'h0); chk("strb_lo", bus0.rsp_rdata, 32'h12345555);

    // Hi word after lo read while the hi word moves underneath.
    op(1'b1, 5'h04, 32'h5, 4'hF);
    op(1'b1, 5'h00, 32'hFFFFFFFE, 4'hF);
    op(1'b0, 5'h00, 32'h0, 4'h0); chk("snap_lo", bus0.rsp_rdata, 32'hFFFFFFFE);
    idle(1);
    op(1'b0, 5'h04, 32'h0, 4'h0);
`ifdef MTIMER_SNAPSHOT_EN
    chk("snap_hi", bus0.rsp_rdata, 32'h5);
`else
    chk("snap_hi", bus0.rsp_rdata, 32'h6);
`endif

    // Reset arriving with a response pending.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'h08;
    @(posedge clk);
    #1 rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("rst_mid_valid0", 32'(bus0.rsp_valid), 32'd0);
    chk("rst_mid_rdata0", bus0.rsp_rdata, 32'd0);
    chk("rst_mid_valid1", 32'(bus1.rsp_valid), 32'd0);
    @(negedge clk);
    idle(1);
    rst_n = 1'b1;
    op(1'b0, 5'h0C, 32'h0, 4'h0); chk("rst_mid_cmp", bus0.rsp_rdata, 32'hFFFFFFFF);

    // Random traffic against the model on both instances.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      idx = $urandom_range(0, 7);
      a   = 5'(idx * 4 + $urandom_range(0, 3));
      case (idx)
        0: v = ($urandom_range(0, 9) == 0) ? (32'hFFFFFFF0 + 32'($urandom_range(0, 15)))
                                             : 32'($urandom_range(0, 400));
        1: v = 32'($urandom_range(0, 2));
        2: v = 32'($urandom_range(0, 400));
        3: v = ($urandom_range(0, 4) == 0) ? 32'hFFFFFFFF : 32'd0;
        default: v = $urandom;
      endcase
      req_valid = ($urandom_range(0, 3) != 0);
      req_write = $urandom_range(0, 1) == 1;
      req_addr  = a;
      req_wdata = v;
      req_wstrb = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      @(posedge clk); @(negedge clk);
    end
    req_valid = 1'b0; req_write = 1'b0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
